prim_cnt_phase_ctrl: RTL and testbench
======================================

# prim_cnt_phase_ctrl

Multi-phase escalation timer controller that sequences an external hardened cross-counter (primary/secondary, sum-checked) through up to `NumPhases` consecutive timeout phases. It loads each phase length into the counter, decrements it once per cycle, signals each phase expiry, and ends in a terminal state. It sits between a control/CSR block and the counter instance. Counter integrity errors and illegal FSM states drive it into a sticky error state.

## Interface
- `Width`, 16: counter and phase-length width.
- `NumPhases`, 4: number of phases, range 2..8; `PhW = $clog2(NumPhases)`.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: start request, level-sampled, accepted only in IDLE.
- `clr_i` in 1: abort and return to IDLE.
- `pause_i` in 1: freeze counting while high.
- `phase_cyc_i` in NumPhases*Width: per-phase length, entry k at bits [k*Width +: Width].
- `active_o` out 1: high in PHASE.
- `phase_o` out PhW: current phase index.
- `expire_o` out 1: one-cycle pulse on phase expiry.
- `done_o` out 1: high in TERM.
- `err_o` out 1: sticky error.
- `cnt_clr_o` out 1: counter clear.
- `cnt_set_o` out 1: counter set.
- `cnt_set_val_o` out Width: counter set value.
- `cnt_decr_o` out 1: counter decrement enable; step is fixed at 1.
- `cnt_step_o` out Width: constant 1.
- `cnt_commit_o` out 1: counter commit.
- `cnt_i` in Width: counter primary value.
- `cnt_err_i` in 1: counter integrity error.

## Operation
- FSM states are IDLE, PHASE, TERM, and ERROR. They use a sparse encoding with minimum Hamming distance 3. Any illegal encoding goes to ERROR.
- `phase_q` (PhW bits) is a registered phase index. Counter outputs are decoded combinationally from the state and inputs. Controller outputs are registered or state-decoded.
- **IDLE:** drive `cnt_clr_o=1` and `cnt_commit_o=1`.
  - On `start_i && !clr_i`: drive `cnt_set_o=1`, `cnt_set_val_o=phase_cyc_i[0]`, and `cnt_clr_o=0`. Set `phase_q<=0` and go to PHASE.
- **PHASE:** `cnt_commit_o=1` unless paused.
  - `clr_i` has priority. Drive `cnt_clr_o=1`, go to IDLE, set `phase_q<=0`.
  - Else if `pause_i`: all counter controls are 0 and the state is held. No expiry is evaluated.
  - Else if `cnt_i != 0`: `cnt_decr_o=1`.
  - Else (`cnt_i == 0`): `expire_o<=1` next cycle, carrying the index of the phase that expired.
    - If `phase_q < NumPhases-1`: drive `cnt_set_o=1` with `phase_cyc_i[phase_q+1]` and increment `phase_q`.
    - Otherwise: drive `cnt_clr_o=1` and go to TERM.
- **TERM:** `done_o=1`, `phase_o` holds `NumPhases-1`, and `cnt_clr_o=1` with commit. `clr_i` returns to IDLE. `start_i` is ignored.
- **ERROR:** entered from any state when `cnt_err_i=1` or the state encoding is illegal.
  - Has priority over `clr_i`, `start_i`, and `pause_i`.
  - All counter controls are 0 and all other outputs are frozen except `err_o=1`.
  - Exit only by `rst_i`.
- `phase_cyc_i` is sampled only in the cycle a phase is loaded. Later changes do not affect the running phase.
- `start_i` outside IDLE is ignored. There is no queuing.

## Timing
- All state and outputs change only on the rising edge of `clk_i`.
- Reset sets state IDLE and `phase_q=0`. While `rst_i=1`: `active_o`, `done_o`, `expire_o`, `err_o` are 0 and `phase_o=0`.
- After reset, IDLE counter controls apply from the first cycle out of reset: `cnt_clr_o=1`, `cnt_commit_o=1`.
- Reset mid-operation aborts immediately. The next cycle is IDLE with no `expire_o`.
- Start latency: start accepted at cycle t gives `active_o=1` and `cnt_i=phase_cyc_i[0]` at t+1.
- A phase of length V with no pause occupies V+1 PHASE cycles. `expire_o` is high in the cycle after the cycle where `cnt_i==0`.
- V=0 is legal and expires on the first PHASE cycle.
- Each pause cycle extends the phase by exactly one cycle.
- Total no-pause runtime is the sum of (V_k+1) cycles. TERM is entered the cycle after the last zero is seen.
- `cnt_err_i` at cycle t gives `err_o=1` at t+1.

## Test plan
1. **Basic run.** NumPhases=4, phase_cyc={3,0,2,1}, start one cycle.
   - Required: `expire_o` pulses 4, 5, 8, and 10 cycles after `active_o` rises, with `phase_o`=0,1,2,3 respectively.
   - Required: `done_o=1` at +10.
   - Required: counter decrements one per cycle; `cnt_commit_o=1` throughout.
2. **Pause.** Same run with `pause_i` high for 5 cycles during phase 0.
   - Required: every subsequent expiry is shifted by +5.
   - Required: no `cnt_decr_o` while paused.
3. **Clear arbitration.**
   - `clr_i` and `start_i` together in IDLE: stays IDLE.
   - `clr_i` in phase 2 with `cnt_i=1`: IDLE next cycle, `cnt_clr_o=1`, no `expire_o`.
   - `clr_i` in TERM: IDLE.
4. **Counter error.** Assert `cnt_err_i` for one cycle in phase 1.
   - Required: `err_o=1` from the next cycle, sticky.
   - Required: counter controls 0; `start_i` and `clr_i` ignored.
   - Required: `rst_i` for one cycle restores IDLE with `err_o=0`.
5. **Illegal state.** Force the state register to a non-codeword.
   - Required: ERROR next cycle and `err_o=1`.
6. **Sampling and boundaries.**
   - `phase_cyc_i[0]=16'hFFFF`: verify the load.
   - Change `phase_cyc_i[0]` to 0 mid-phase: no effect on the running phase.
   - `start_i` held in TERM: ignored.
   - Reset mid-phase: IDLE and `cnt_clr_o=1` the next cycle.

Source files
------------

// File: rtl/prim_cnt_phase_ctrl.sv
// Multi-phase escalation timer controller: sequences an external cross-counter
// through NumPhases timeout phases, pulsing expire_o per phase and ending in TERM.
module prim_cnt_phase_ctrl #(
  parameter int Width     = 16,
  parameter int NumPhases = 4,
  localparam int PhW      = $clog2(NumPhases)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       clr_i,
  input  logic                       pause_i,
  input  logic [NumPhases*Width-1:0] phase_cyc_i,
  output logic                       active_o,
  output logic [PhW-1:0]             phase_o,
  output logic                       expire_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic                       cnt_clr_o,
  output logic                       cnt_set_o,
  output logic [Width-1:0]           cnt_set_val_o,
  output logic                       cnt_decr_o,
  output logic [Width-1:0]           cnt_step_o,
  output logic                       cnt_commit_o,
  input  logic [Width-1:0]           cnt_i,
  input  logic                       cnt_err_i
);

  // Codewords are pairwise at Hamming distance >= 3.
  typedef enum logic [4:0] {
    IDLE  = 5'b01011,
    PHASE = 5'b10101,
    TERM  = 5'b11110,
    ERROR = 5'b00000
  } state_e;

  // Held as raw bits so that any corrupted value is representable and decodes to ERROR.
  logic [4:0]     state_q;
  state_e         state_d;
  logic [PhW-1:0] phase_q, phase_d, phase_nxt;
  logic           expire_d;
  logic [Width-1:0] phase_len [2**PhW];

  for (genvar k = 0; k < 2**PhW; k++) begin : g_len
    if (k < NumPhases) begin : g_in
      assign phase_len[k] = phase_cyc_i[k*Width +: Width];
    end else begin : g_pad
      assign phase_len[k] = '0;
    end
  end

  assign phase_nxt  = phase_q + PhW'(1);
  assign cnt_step_o = Width'(1);

  always_comb begin
    state_d       = ERROR;
    phase_d       = phase_q;
    expire_d      = 1'b0;
    cnt_clr_o     = 1'b0;
    cnt_set_o     = 1'b0;
    cnt_set_val_o = '0;
    cnt_decr_o    = 1'b0;
    cnt_commit_o  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d      = IDLE;
        cnt_commit_o = 1'b1;
        if (start_i && !clr_i) begin
          cnt_set_o     = 1'b1;
          cnt_set_val_o = phase_len[0];
          phase_d       = '0;
          state_d       = PHASE;
        end else begin
          cnt_clr_o = 1'b1;
        end
      end
      PHASE: begin
        state_d = PHASE;
        if (clr_i) begin
          cnt_clr_o    = 1'b1;
          cnt_commit_o = 1'b1;
          phase_d      = '0;
          state_d      = IDLE;
        end else if (!pause_i) begin
          cnt_commit_o = 1'b1;
          if (cnt_i != '0) begin
            cnt_decr_o = 1'b1;
          end else begin
            expire_d = 1'b1;
            if (phase_q != PhW'(NumPhases-1)) begin
              cnt_set_o     = 1'b1;
              cnt_set_val_o = phase_len[phase_nxt];
              phase_d       = phase_nxt;
            end else begin
              cnt_clr_o = 1'b1;
              state_d   = TERM;
            end
          end
        end
      end
      TERM: begin
        state_d      = TERM;
        cnt_clr_o    = 1'b1;
        cnt_commit_o = 1'b1;
        if (clr_i) begin
          phase_d = '0;
          state_d = IDLE;
        end
      end
      default: ;
    endcase
    // A corrupted counter must not be driven any further.
    if (cnt_err_i) begin
      state_d       = ERROR;
      phase_d       = phase_q;
      expire_d      = 1'b0;
      cnt_clr_o     = 1'b0;
      cnt_set_o     = 1'b0;
      cnt_set_val_o = '0;
      cnt_decr_o    = 1'b0;
      cnt_commit_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      active_o <= 1'b0;
      done_o   <= 1'b0;
      expire_o <= 1'b0;
      err_o    <= 1'b0;
      phase_o  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      if (state_d == ERROR) begin
        err_o <= 1'b1;
      end else begin
        active_o <= (state_d == PHASE);
        done_o   <= (state_d == TERM);
        expire_o <= expire_d;
        // During the expiry pulse report the phase that just ended.
        phase_o  <= expire_d ? phase_q : phase_d;
      end
    end
  end

endmodule

// File: tb/tb_prim_cnt_phase_ctrl.sv
// Randomized bench for prim_cnt_phase_ctrl with a behavioural counter and an
// arithmetic schedule model of expiry times.
module tb_prim_cnt_phase_ctrl;
  localparam int Width = 16;
  localparam int NumPhases = 4;
  localparam int PhW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, clr = 1'b0, pause = 1'b0, cnt_err = 1'b0;
  logic [NumPhases*Width-1:0] phase_cyc = '0;
  logic active, expire, done, err, cnt_clr, cnt_set, cnt_decr, cnt_commit;
  logic [PhW-1:0] phase;
  logic [Width-1:0] cnt_set_val, cnt_step;
  logic [Width-1:0] cnt = '0;
  int total = 0;
  int bad = 0;

  prim_cnt_phase_ctrl #(.Width(Width), .NumPhases(NumPhases)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr), .pause_i(pause),
    .phase_cyc_i(phase_cyc), .active_o(active), .phase_o(phase), .expire_o(expire),
    .done_o(done), .err_o(err), .cnt_clr_o(cnt_clr), .cnt_set_o(cnt_set),
    .cnt_set_val_o(cnt_set_val), .cnt_decr_o(cnt_decr), .cnt_step_o(cnt_step),
    .cnt_commit_o(cnt_commit), .cnt_i(cnt), .cnt_err_i(cnt_err)
  );

  // External counter stand-in: updates only on commit.
  always @(posedge clk) begin
    if (cnt_commit) begin
      if (cnt_clr)       cnt <= '0;
      else if (cnt_set)  cnt <= cnt_set_val;
      else if (cnt_decr) cnt <= cnt - cnt_step;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({active, done, expire, err, phase} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0", {active, done, expire, err, phase});
    end
    rst = 1'b0;
    #1;
    total++;
    if ({cnt_clr, cnt_commit, cnt_set, cnt_decr} !== 4'b1100 || cnt_step !== 16'd1) begin
      bad++;
      $display("FAIL idle_ctrl got=%b step=%0d exp=1100 step=1",
               {cnt_clr, cnt_commit, cnt_set, cnt_decr}, cnt_step);
    end
  endtask

  task automatic go_idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if (active !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL go_idle got active=%b done=%b exp=0 0", active, done);
    end
  endtask

  // Runs all phases with pause cycles [p, p+n) counted from the first PHASE cycle.
  task automatic run_phases(input logic [NumPhases*Width-1:0] cyc, input int p,
                            input int n, input string name);
    int exp_off[$];
    int obs_off[$];
    int obs_ph[$];
    int acc, vsum, decrs, limit;
    logic bad_ctl;
    acc = n;
    vsum = 0;
    for (int k = 0; k < NumPhases; k++) begin
      acc += int'(cyc[k*Width +: Width]) + 1;
      vsum += int'(cyc[k*Width +: Width]);
      exp_off.push_back(acc);
    end
    limit = acc;
    phase_cyc = cyc;
    start = 1'b1;
    #1;
    total++;
    if (cnt_set !== 1'b1 || cnt_clr !== 1'b0 || cnt_set_val !== cyc[Width-1:0]) begin
      bad++;
      $display("FAIL %s start_load got set=%b clr=%b val=%h exp 1 0 %h",
               name, cnt_set, cnt_clr, cnt_set_val, cyc[Width-1:0]);
    end
    tick();
    start = 1'b0;
    total++;
    if (active !== 1'b1 || cnt !== cyc[Width-1:0]) begin
      bad++;
      $display("FAIL %s start_latency got active=%b cnt=%h exp 1 %h",
               name, active, cnt, cyc[Width-1:0]);
    end
    decrs = 0;
    bad_ctl = 1'b0;
    for (int o = 0; o <= limit; o++) begin
      if (o > 0) tick();
      if (expire === 1'b1) begin
        obs_off.push_back(o);
        obs_ph.push_back(int'(phase));
      end
      if (o == limit - 1) begin
        total++;
        if (done !== 1'b0) begin
          bad++;
          $display("FAIL %s done_early got=%b exp=0", name, done);
        end
      end
      if (o == limit) begin
        total++;
        if (done !== 1'b1 || active !== 1'b0) begin
          bad++;
          $display("FAIL %s done_at_end got done=%b active=%b exp 1 0", name, done, active);
        end
      end
      pause = (o >= p && o < p + n);
      #1;
      if (o < limit) begin
        if (pause) bad_ctl = bad_ctl | cnt_decr | cnt_commit | cnt_set | cnt_clr;
        else       bad_ctl = bad_ctl | ~cnt_commit;
      end
      if (cnt_decr === 1'b1) decrs++;
    end
    pause = 1'b0;
    total++;
    if (obs_off.size() != NumPhases) begin
      bad++;
      $display("FAIL %s expire_count got=%0d exp=%0d", name, obs_off.size(), NumPhases);
    end else begin
      for (int k = 0; k < NumPhases; k++) begin
        total++;
        if (obs_off[k] != exp_off[k] || obs_ph[k] != k) begin
          bad++;
          $display("FAIL %s expire_%0d got off=%0d ph=%0d exp off=%0d ph=%0d",
                   name, k, obs_off[k], obs_ph[k], exp_off[k], k);
        end
      end
    end
    total++;
    if (decrs != vsum || bad_ctl !== 1'b0) begin
      bad++;
      $display("FAIL %s decr_commit got decrs=%0d badctl=%b exp decrs=%0d badctl=0",
               name, decrs, bad_ctl, vsum);
    end
  endtask

  task automatic test_basic();
    run_phases({16'd1, 16'd2, 16'd0, 16'd3}, 0, 0, "basic");
    go_idle();
  endtask

  task automatic test_pause();
    run_phases({16'd1, 16'd2, 16'd0, 16'd3}, 1, 5, "pause");
    go_idle();
  endtask

  task automatic test_random();
    logic [NumPhases*Width-1:0] cyc;
    int p, n;
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < NumPhases; k++) cyc[k*Width +: Width] = Width'($urandom_range(0, 6));
      p = $urandom_range(0, int'(cyc[Width-1:0]));
      n = $urandom_range(0, 4);
      run_phases(cyc, p, n, "random");
      go_idle();
    end
  endtask

  task automatic test_clear();
    int guard;
    clr = 1'b1;
    start = 1'b1;
    #1;
    total++;
    if (cnt_set !== 1'b0 || cnt_clr !== 1'b1) begin
      bad++;
      $display("FAIL clr_start_idle_ctrl got set=%b clr=%b exp 0 1", cnt_set, cnt_clr);
    end
    tick();
    clr = 1'b0;
    start = 1'b0;
    total++;
    if (active !== 1'b0) begin
      bad++;
      $display("FAIL clr_start_idle got active=%b exp=0", active);
    end
    phase_cyc = {16'd1, 16'd2, 16'd0, 16'd3};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (cnt !== 16'd1 || phase !== 2'd2) begin
      bad++;
      $display("FAIL clr_phase2_pos got cnt=%0d phase=%0d exp 1 2", cnt, phase);
    end
    clr = 1'b1;
    #1;
    total++;
    if (cnt_clr !== 1'b1 || cnt_decr !== 1'b0) begin
      bad++;
      $display("FAIL clr_phase2_ctrl got clr=%b decr=%b exp 1 0", cnt_clr, cnt_decr);
    end
    tick();
    clr = 1'b0;
    total++;
    if (active !== 1'b0 || expire !== 1'b0 || phase !== 2'd0 || cnt !== 16'd0) begin
      bad++;
      $display("FAIL clr_phase2_idle got act=%b exp=%b ph=%0d cnt=%0d exp 0 0 0 0",
               active, expire, phase, cnt);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (done !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    start = 1'b1;
    tick();
    tick();
    tick();
    total++;
    if (done !== 1'b1 || active !== 1'b0 || phase !== 2'd3 || cnt_set !== 1'b0) begin
      bad++;
      $display("FAIL term_start_ignored got done=%b act=%b ph=%0d set=%b exp 1 0 3 0",
               done, active, phase, cnt_set);
    end
    start = 1'b0;
    go_idle();
  endtask

  task automatic test_cnt_err();
    phase_cyc = {16'd1, 16'd2, 16'd5, 16'd2};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    cnt_err = 1'b1;
    tick();
    cnt_err = 1'b0;
    total++;
    if (err !== 1'b1 || active !== 1'b1 || phase !== 2'd1) begin
      bad++;
      $display("FAIL cnt_err_entry got err=%b act=%b ph=%0d exp 1 1 1", err, active, phase);
    end
    start = 1'b1;
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({cnt_clr, cnt_set, cnt_decr, cnt_commit} !== 4'b0000 || err !== 1'b1) begin
        bad++;
        $display("FAIL cnt_err_sticky got ctl=%b err=%b exp 0000 1",
                 {cnt_clr, cnt_set, cnt_decr, cnt_commit}, err);
      end
      tick();
    end
    start = 1'b0;
    clr = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (err !== 1'b0 || active !== 1'b0 || cnt_clr !== 1'b1 || cnt_commit !== 1'b1) begin
      bad++;
      $display("FAIL cnt_err_reset got err=%b act=%b clr=%b commit=%b exp 0 0 1 1",
               err, active, cnt_clr, cnt_commit);
    end
  endtask

  task automatic test_illegal_state();
    force dut.state_q = 5'b11111;
    #1;
    total++;
    if (cnt_clr !== 1'b0 || cnt_commit !== 1'b0) begin
      bad++;
      $display("FAIL illegal_ctrl got clr=%b commit=%b exp 0 0", cnt_clr, cnt_commit);
    end
    tick();
    release dut.state_q;
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL illegal_err got=%b exp=1", err);
    end
    tick();
    total++;
    if (err !== 1'b1 || cnt_commit !== 1'b0) begin
      bad++;
      $display("FAIL illegal_sticky got err=%b commit=%b exp 1 0", err, cnt_commit);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_boundaries();
    phase_cyc = {16'd1, 16'd1, 16'd1, 16'hFFFF};
    start = 1'b1;
    #1;
    total++;
    if (cnt_set_val !== 16'hFFFF) begin
      bad++;
      $display("FAIL max_load_val got=%h exp=ffff", cnt_set_val);
    end
    tick();
    start = 1'b0;
    total++;
    if (cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL max_load_cnt got=%h exp=ffff", cnt);
    end
    phase_cyc[Width-1:0] = '0;
    tick();
    tick();
    tick();
    total++;
    if (cnt !== 16'hFFFC || expire !== 1'b0 || active !== 1'b1) begin
      bad++;
      $display("FAIL sample_once got cnt=%h exp_o=%b act=%b exp fffc 0 1", cnt, expire, active);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (active !== 1'b0 || expire !== 1'b0 || cnt_clr !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_phase got act=%b exp_o=%b clr=%b exp 0 0 1",
               active, expire, cnt_clr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_clear();
    test_cnt_err();
    test_illegal_state();
    test_boundaries();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
